// File: rtl/conv_kernel_scheduler.sv
// Runs the 3x3 line-buffered convolution datapath over the stored image once per kernel:
// fetch the kernel word, flush the datapath, stream all pixels, forward tagged results.
module conv_kernel_scheduler #(
   parameter  int input_width   = 8,
   parameter  int k_width       = 12,
   parameter  int k_size        = 9,
   parameter  int im_dim        = 28,
   parameter  int n_kernels     = 4,
   parameter  int drain_timeout = 64,
   localparam int KAW           = (n_kernels > 1) ? $clog2(n_kernels) : 1,
   localparam int AW            = $clog2(im_dim * im_dim),
   localparam int KVW           = k_width * k_size
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o,
   output logic [KAW-1:0]         kmem_addr_o,
   input  logic [KVW-1:0]         kmem_data_i,
   output logic [AW-1:0]          img_addr_o,
   input  logic [input_width-1:0] img_data_i,
   output logic                   filt_rst_no,
   output logic [KVW-1:0]         filt_k_val_o,
   output logic [input_width-1:0] filt_pixel_o,
   output logic                   filt_pix_valid_o,
   input  logic [7:0]             filt_pixel_i,
   input  logic                   filt_conv_finished_i,
   input  logic                   filt_finished_i,
   output logic [7:0]             out_pixel_o,
   output logic                   out_valid_o,
   output logic [KAW-1:0]         out_kernel_o,
   output logic                   out_last_o,
   output logic [2:0]             dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_K, S_LATCH_K, S_FLUSH, S_STREAM, S_DRAIN, S_NEXT
   } state_t;

   localparam int NPIX = im_dim * im_dim;
   localparam int NOUT = (im_dim - 2) * (im_dim - 2);
   localparam int OW   = $clog2(NOUT + 1);
   localparam int DW   = $clog2(drain_timeout + 1);

   localparam logic [AW-1:0]  PIX_LAST   = AW'(NPIX - 1);
   localparam logic [OW-1:0]  OUT_LAST   = OW'(NOUT - 1);
   localparam logic [OW-1:0]  OUT_FULL   = OW'(NOUT);
   localparam logic [DW-1:0]  DRAIN_LAST = DW'(drain_timeout - 1);
   localparam logic [KAW-1:0] K_LAST     = KAW'(n_kernels - 1);

   state_t           state_q, state_d;
   logic [KAW-1:0]   k_idx_q, k_idx_d;
   logic             flush_q, flush_d;
   logic [AW-1:0]    pix_cnt_q, pix_cnt_d;
   logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
   logic [OW-1:0]    out_cnt_q, out_cnt_d;
   logic             err_q, err_d;
   logic [KVW-1:0]   k_val_q, k_val_d;
   logic             pix_valid_q, pix_valid_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic [7:0]       out_pixel_q, out_pixel_d;
   logic [KAW-1:0]   out_kernel_q, out_kernel_d;
   logic             done;

   always_comb begin
      state_d      = state_q;
      k_idx_d      = k_idx_q;
      flush_d      = flush_q;
      pix_cnt_d    = pix_cnt_q;
      drain_cnt_d  = drain_cnt_q;
      out_cnt_d    = out_cnt_q;
      err_d        = err_q;
      k_val_d      = k_val_q;
      pix_valid_d  = 1'b0;
      out_valid_d  = 1'b0;
      out_last_d   = 1'b0;
      out_pixel_d  = out_pixel_q;
      out_kernel_d = out_kernel_q;
      done         = 1'b0;

      // Results are accepted only while an image is in flight; overflow is dropped and flagged.
      if ((state_q == S_STREAM || state_q == S_DRAIN) && filt_conv_finished_i) begin
         if (out_cnt_q < OUT_FULL) begin
            out_valid_d  = 1'b1;
            out_last_d   = (out_cnt_q == OUT_LAST);
            out_pixel_d  = filt_pixel_i;
            out_kernel_d = k_idx_q;
            out_cnt_d    = out_cnt_q + 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_LOAD_K;
               k_idx_d = '0;
               err_d   = 1'b0;
            end
         end
         S_LOAD_K:  state_d = S_LATCH_K;
         S_LATCH_K: begin
            k_val_d = kmem_data_i;
            flush_d = 1'b0;
            state_d = S_FLUSH;
         end
         S_FLUSH: begin
            pix_cnt_d   = '0;
            out_cnt_d   = '0;
            drain_cnt_d = '0;
            flush_d     = 1'b1;
            if (flush_q) begin
               flush_d = 1'b0;
               state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            pix_valid_d = 1'b1;
            if (pix_cnt_q == PIX_LAST) state_d = S_DRAIN;
            else                       pix_cnt_d = pix_cnt_q + 1'b1;
         end
         S_DRAIN: begin
            drain_cnt_d = drain_cnt_q + 1'b1;
            if (filt_finished_i) begin
               state_d = S_NEXT;
               if (out_cnt_d != OUT_FULL) err_d = 1'b1;
            end else if (drain_cnt_q == DRAIN_LAST) begin
               err_d   = 1'b1;
               state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            if (k_idx_q == K_LAST) begin
               done    = 1'b1;
               state_d = S_IDLE;
            end else begin
               k_idx_d = k_idx_q + 1'b1;
               state_d = S_LOAD_K;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         k_idx_q      <= '0;
         flush_q      <= 1'b0;
         pix_cnt_q    <= '0;
         drain_cnt_q  <= '0;
         out_cnt_q    <= '0;
         err_q        <= 1'b0;
         k_val_q      <= '0;
         pix_valid_q  <= 1'b0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_pixel_q  <= '0;
         out_kernel_q <= '0;
      end else begin
         state_q      <= state_d;
         k_idx_q      <= k_idx_d;
         flush_q      <= flush_d;
         pix_cnt_q    <= pix_cnt_d;
         drain_cnt_q  <= drain_cnt_d;
         out_cnt_q    <= out_cnt_d;
         err_q        <= err_d;
         k_val_q      <= k_val_d;
         pix_valid_q  <= pix_valid_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         out_pixel_q  <= out_pixel_d;
         out_kernel_q <= out_kernel_d;
      end
   end

   // The image BRAM output register already supplies the cycle of delay; gate it with the valid.
   assign filt_pixel_o     = pix_valid_q ? img_data_i : '0;
   assign filt_pix_valid_o = pix_valid_q;
   assign filt_rst_no      = ~rst_i & (state_q != S_FLUSH);
   assign filt_k_val_o     = k_val_q;
   assign kmem_addr_o      = k_idx_q;
   assign img_addr_o       = pix_cnt_q;
   assign busy_o           = (state_q != S_IDLE);
   assign done_o           = done;
   assign err_o            = err_q;
   assign out_pixel_o      = out_pixel_q;
   assign out_valid_o      = out_valid_q;
   assign out_kernel_o     = out_kernel_q;
   assign out_last_o       = out_last_q;
   assign dbg_state_o      = state_q;

endmodule
